teste_2: RTL and testbench



---
 rtl/can_dec_pkg.sv | 26 ++
 rtl/can_destuffer.sv | 41 ++++
 rtl/teste_2.sv | 219 +++++++++++++++++++++
 tb/tb_teste_2.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/can_dec_pkg.sv
// Shared types and field widths for the CAN 2.0A/2.0B frame decoder.
// Includes the data-field length helper used by the frame FSM.
package can_dec_pkg;

   typedef enum logic [3:0] {
      IDLE, ID11, SRR_RTR, IDE, ID18, RTR_EXT, RSV,
      DLC, DATA, CRC, CRC_DEL, ACK, EOF
   } state_t;

   localparam int ID_STD_W       = 11;
   localparam int ID_EXT_W       = 18;
   localparam int DLC_W          = 4;
   localparam int CRC_W          = 15;
   localparam int EOF_W          = 7;
   localparam int MAX_DATA_BYTES = 8;
   localparam int STUFF_LIMIT    = 5;

   // DLC values 9..15 still carry only eight bytes
   function automatic logic [6:0] data_bits(input logic [DLC_W-1:0] dlc);
      if (dlc >= 4'(MAX_DATA_BYTES))
         return 7'(MAX_DATA_BYTES * 8);
      else
         return {1'b0, dlc[2:0], 3'b000};
   endfunction

endpackage

// File: rtl/can_destuffer.sv
// Tracks the bus-level run length and flags stuff bits (dropped) and stuff errors.
// Combinational verdict on the current bit; run state updates on the rising edge of sample.
module can_destuffer
   import can_dec_pkg::*;
(
   input  logic sample,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   input  logic din,
   output logic bit_valid,
   output logic stuff_err
);

   logic       last;
   logic [2:0] run;
   logic       pending;

   assign pending   = (run == 3'(STUFF_LIMIT));
   assign bit_valid = en && !pending;
   assign stuff_err = en && pending && (din == last);

   always_ff @(posedge sample or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
         run  <= 3'd0;
      end else if (clear) begin
         // SOF itself opens the first run
         last <= din;
         run  <= 3'd1;
      end else if (en) begin
         if (pending || din != last) begin
            last <= din;
            run  <= 3'd1;
         end else begin
            run <= run + 3'd1;
         end
      end
   end

endmodule

// File: rtl/teste_2.sv
// Bit-serial CAN frame decoder: destuffs SOF..CRC, splits fields, loads all outputs at once.
// Outputs and the one-cycle getframe strobe update on the edge sampling the 7th EOF bit.
module teste_2
   import can_dec_pkg::*;
(
   input  logic        sample,
   input  logic        rst_n,
   input  logic        can_data,
   output logic [10:0] bit_id_11,
   output logic [28:0] bit_id_29,
   output logic [1:0]  srr_rtr_ide,
   output logic        rtr_ext,
   output logic        std_frame,
   output logic        ext_frame,
   output logic        data_frame,
   output logic        remote_frame,
   output logic [3:0]  data_size,
   output logic [64:0] data_field,
   output logic [14:0] crc_field,
   output logic        crc_delimiter,
   output logic [1:0]  ack_field,
   output logic [6:0]  end_of_frame,
   output logic        getframe
);

   state_t                state;
   logic [6:0]            cnt;
   logic [ID_STD_W-1:0]   id_std_sh;
   logic [ID_EXT_W-1:0]   id_ext_sh;
   logic                  srr_rtr_bit;
   logic                  ide_bit;
   logic                  rtr_x_bit;
   logic [DLC_W-1:0]      dlc_sh;
   logic [63:0]           data_sh;
   logic [CRC_W-1:0]      crc_sh;
   logic                  crc_del_bit;
   logic                  ack_slot_bit;
   logic [EOF_W-2:0]      eof_sh;

   logic                  sof;
   logic                  stuffed;
   logic                  step;
   logic                  bit_valid;
   logic                  stuff_err;
   logic                  eff_rtr;
   logic [DLC_W-1:0]      dlc_next;

   assign sof      = (state == IDLE) && !can_data;
   // CRC_DEL stays enabled so a stuff bit after the last CRC bit is absorbed
   assign stuffed  = (state inside {ID11, SRR_RTR, IDE, ID18, RTR_EXT, RSV,
                                    DLC, DATA, CRC, CRC_DEL});
   assign step     = !stuffed || bit_valid;
   assign eff_rtr  = ide_bit ? rtr_x_bit : srr_rtr_bit;
   assign dlc_next = {dlc_sh[DLC_W-2:0], can_data};

   can_destuffer u_destuffer (
      .sample    (sample),
      .rst_n     (rst_n),
      .clear     (sof),
      .en        (stuffed),
      .din       (can_data),
      .bit_valid (bit_valid),
      .stuff_err (stuff_err)
   );

   always_ff @(posedge sample or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         id_std_sh     <= '0;
         id_ext_sh     <= '0;
         srr_rtr_bit   <= 1'b0;
         ide_bit       <= 1'b0;
         rtr_x_bit     <= 1'b0;
         dlc_sh        <= '0;
         data_sh       <= '0;
         crc_sh        <= '0;
         crc_del_bit   <= 1'b0;
         ack_slot_bit  <= 1'b0;
         eof_sh        <= '0;
         bit_id_11     <= '0;
         bit_id_29     <= '0;
         srr_rtr_ide   <= '0;
         rtr_ext       <= 1'b0;
         std_frame     <= 1'b0;
         ext_frame     <= 1'b0;
         data_frame    <= 1'b0;
         remote_frame  <= 1'b0;
         data_size     <= '0;
         data_field    <= '0;
         crc_field     <= '0;
         crc_delimiter <= 1'b0;
         ack_field     <= '0;
         end_of_frame  <= '0;
         getframe      <= 1'b0;
      end else begin
         getframe <= 1'b0;
         if (stuff_err) begin
            state <= IDLE;
         end else if (step) begin
            case (state)
               IDLE: if (sof) begin
                  cnt         <= '0;
                  id_std_sh   <= '0;
                  id_ext_sh   <= '0;
                  srr_rtr_bit <= 1'b0;
                  ide_bit     <= 1'b0;
                  rtr_x_bit   <= 1'b0;
                  dlc_sh      <= '0;
                  data_sh     <= '0;
                  crc_sh      <= '0;
                  state       <= ID11;
               end
               ID11: begin
                  id_std_sh <= {id_std_sh[ID_STD_W-2:0], can_data};
                  cnt       <= cnt + 7'd1;
                  if (cnt == 7'(ID_STD_W - 1)) begin
                     cnt   <= '0;
                     state <= SRR_RTR;
                  end
               end
               SRR_RTR: begin
                  srr_rtr_bit <= can_data;
                  state       <= IDE;
               end
               IDE: begin
                  ide_bit <= can_data;
                  cnt     <= '0;
                  state   <= can_data ? ID18 : RSV;
               end
               ID18: begin
                  id_ext_sh <= {id_ext_sh[ID_EXT_W-2:0], can_data};
                  cnt       <= cnt + 7'd1;
                  if (cnt == 7'(ID_EXT_W - 1)) begin
                     cnt   <= '0;
                     state <= RTR_EXT;
                  end
               end
               RTR_EXT: begin
                  rtr_x_bit <= can_data;
                  cnt       <= '0;
                  state     <= RSV;
               end
               RSV: begin
                  // r0 only for standard frames, r1 and r0 for extended
                  cnt <= cnt + 7'd1;
                  if (cnt == (ide_bit ? 7'd1 : 7'd0)) begin
                     cnt   <= '0;
                     state <= DLC;
                  end
               end
               DLC: begin
                  dlc_sh <= dlc_next;
                  cnt    <= cnt + 7'd1;
                  if (cnt == 7'(DLC_W - 1)) begin
                     cnt   <= '0;
                     state <= (eff_rtr || dlc_next == '0) ? CRC : DATA;
                  end
               end
               DATA: begin
                  data_sh <= {data_sh[62:0], can_data};
                  cnt     <= cnt + 7'd1;
                  if (cnt == data_bits(dlc_sh) - 7'd1) begin
                     cnt   <= '0;
                     state <= CRC;
                  end
               end
               CRC: begin
                  crc_sh <= {crc_sh[CRC_W-2:0], can_data};
                  cnt    <= cnt + 7'd1;
                  if (cnt == 7'(CRC_W - 1)) begin
                     cnt   <= '0;
                     state <= CRC_DEL;
                  end
               end
               CRC_DEL: begin
                  crc_del_bit <= can_data;
                  cnt         <= '0;
                  state       <= ACK;
               end
               ACK: begin
                  cnt <= cnt + 7'd1;
                  if (cnt == 7'd0) begin
                     ack_slot_bit <= can_data;
                  end else begin
                     ack_field <= {ack_slot_bit, can_data};
                     cnt       <= '0;
                     state     <= EOF;
                  end
               end
               EOF: begin
                  eof_sh <= {eof_sh[EOF_W-3:0], can_data};
                  cnt    <= cnt + 7'd1;
                  if (cnt == 7'(EOF_W - 1)) begin
                     cnt           <= '0;
                     state         <= IDLE;
                     getframe      <= 1'b1;
                     end_of_frame  <= {eof_sh, can_data};
                     bit_id_11     <= id_std_sh;
                     bit_id_29     <= ide_bit ? {id_std_sh, id_ext_sh} : '0;
                     srr_rtr_ide   <= {srr_rtr_bit, ide_bit};
                     rtr_ext       <= ide_bit & rtr_x_bit;
                     std_frame     <= !ide_bit;
                     ext_frame     <= ide_bit;
                     data_frame    <= !eff_rtr;
                     remote_frame  <= eff_rtr;
                     data_size     <= dlc_sh;
                     data_field    <= {1'b0, data_sh};
                     crc_field     <= crc_sh;
                     crc_delimiter <= crc_del_bit;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_teste_2.sv
// Scoreboard bench for teste_2: frames are built and stuffed here, expected fields queued per frame.
module tb_teste_2;

   logic        sample = 1'b0;
   logic        rst_n;
   logic        can_data;
   logic [10:0] bit_id_11;
   logic [28:0] bit_id_29;
   logic [1:0]  srr_rtr_ide;
   logic        rtr_ext;
   logic        std_frame;
   logic        ext_frame;
   logic        data_frame;
   logic        remote_frame;
   logic [3:0]  data_size;
   logic [64:0] data_field;
   logic [14:0] crc_field;
   logic        crc_delimiter;
   logic [1:0]  ack_field;
   logic [6:0]  end_of_frame;
   logic        getframe;

   teste_2 dut (
      .sample        (sample),
      .rst_n         (rst_n),
      .can_data      (can_data),
      .bit_id_11     (bit_id_11),
      .bit_id_29     (bit_id_29),
      .srr_rtr_ide   (srr_rtr_ide),
      .rtr_ext       (rtr_ext),
      .std_frame     (std_frame),
      .ext_frame     (ext_frame),
      .data_frame    (data_frame),
      .remote_frame  (remote_frame),
      .data_size     (data_size),
      .data_field    (data_field),
      .crc_field     (crc_field),
      .crc_delimiter (crc_delimiter),
      .ack_field     (ack_field),
      .end_of_frame  (end_of_frame),
      .getframe      (getframe)
   );

   always #5 sample = ~sample;

   typedef struct {
      logic [10:0] id11;
      logic [28:0] id29;
      logic [1:0]  sri;
      logic        rtr_ext;
      logic        std_f;
      logic        ext_f;
      logic        dat_f;
      logic        rem_f;
      logic [3:0]  size;
      logic [64:0] data;
      logic [14:0] crc;
   } exp_t;

   exp_t sb[$];
   exp_t got_e;
   exp_t last_exp;
   exp_t e;
   bit   bits[$];
   int   checks   = 0;
   int   failures = 0;
   logic prev_gf  = 1'b0;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Builds the on-wire bit sequence (stuffed SOF..CRC, then the fixed tail) and the expected fields
   task automatic build(input logic ide, input logic [10:0] id11, input logic [17:0] id18,
                        input logic rtr, input logic [3:0] dlc, input logic [63:0] dat,
                        input logic [14:0] crc, output exp_t x);
      bit raw[$];
      int nbits;
      int run;
      bit lastb;
      raw.push_back(1'b0);
      for (int i = 10; i >= 0; i--) raw.push_back(id11[i]);
      if (ide) begin
         raw.push_back(1'b1);
         raw.push_back(1'b1);
         for (int i = 17; i >= 0; i--) raw.push_back(id18[i]);
         raw.push_back(rtr);
         raw.push_back(1'b0);
         raw.push_back(1'b0);
      end else begin
         raw.push_back(rtr);
         raw.push_back(1'b0);
         raw.push_back(1'b0);
      end
      for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
      nbits = rtr ? 0 : ((dlc > 4'd8) ? 64 : int'(dlc) * 8);
      for (int i = nbits - 1; i >= 0; i--) raw.push_back(dat[i]);
      for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
      bits.delete();
      run   = 0;
      lastb = 1'b0;
      foreach (raw[i]) begin
         bits.push_back(raw[i]);
         if (run > 0 && raw[i] == lastb) run++;
         else begin
            run   = 1;
            lastb = raw[i];
         end
         if (run == 5) begin
            bits.push_back(!lastb);
            lastb = !lastb;
            run   = 1;
         end
      end
      bits.push_back(1'b1);                    // CRC delimiter
      bits.push_back(1'b0);                    // ACK slot
      bits.push_back(1'b1);                    // ACK delimiter
      repeat (7) bits.push_back(1'b1);         // EOF
      repeat (3) bits.push_back(1'b1);         // intermission
      x.id11    = id11;
      x.id29    = ide ? {id11, id18} : 29'd0;
      x.sri     = ide ? 2'b11 : {rtr, 1'b0};
      x.rtr_ext = ide & rtr;
      x.std_f   = !ide;
      x.ext_f   = ide;
      x.dat_f   = !rtr;
      x.rem_f   = rtr;
      x.size    = dlc;
      x.data    = '0;
      for (int i = 0; i < nbits; i++) x.data[i] = dat[i];
      x.crc     = crc;
   endtask

   task automatic send(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge sample);
         can_data = bits[i];
      end
   endtask

   always @(negedge sample) begin
      if (prev_gf) check("getframe_one_cycle", getframe, 1'b0);
      prev_gf <= getframe;
      if (getframe) begin
         if (sb.size() == 0) begin
            check("spurious_getframe", getframe, 1'b0);
         end else begin
            got_e = sb.pop_front();
            last_exp = got_e;
            check("bit_id_11",     bit_id_11,     got_e.id11);
            check("bit_id_29",     bit_id_29,     got_e.id29);
            check("srr_rtr_ide",   srr_rtr_ide,   got_e.sri);
            check("rtr_ext",       rtr_ext,       got_e.rtr_ext);
            check("std_frame",     std_frame,     got_e.std_f);
            check("ext_frame",     ext_frame,     got_e.ext_f);
            check("data_frame",    data_frame,    got_e.dat_f);
            check("remote_frame",  remote_frame,  got_e.rem_f);
            check("data_size",     data_size,     got_e.size);
            check("data_field",    data_field,    got_e.data);
            check("crc_field",     crc_field,     got_e.crc);
            check("crc_delimiter", crc_delimiter, 1'b1);
            check("ack_field",     ack_field,     2'b01);
            check("end_of_frame",  end_of_frame,  7'h7F);
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      can_data = 1'b1;
      repeat (3) @(negedge sample);
      check("rst_getframe",   getframe,   1'b0);
      check("rst_bit_id_11",  bit_id_11,  11'd0);
      check("rst_bit_id_29",  bit_id_29,  29'd0);
      check("rst_data_field", data_field, 65'd0);
      check("rst_std_frame",  std_frame,  1'b0);
      check("rst_eof",        end_of_frame, 7'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge sample);

      // standard data, standard remote, extended data, extended remote
      build(1'b0, 11'h123, 18'h0, 1'b0, 4'd2, 64'hA55A, 15'h2C4D, e);
      sb.push_back(e); send(bits.size());
      build(1'b0, 11'h551, 18'h0, 1'b1, 4'd0, 64'h0, 15'h0F0F, e);
      sb.push_back(e); send(bits.size());
      build(1'b1, 11'h552, 18'h08320, 1'b0, 4'd8, 64'h0123456789ABCDEF, 15'h7FF0, e);
      sb.push_back(e); send(bits.size());
      build(1'b1, 11'h552, 18'h08320, 1'b1, 4'd3, 64'hFFFF, 15'h1111, e);
      sb.push_back(e); send(bits.size());

      // six dominant bits inside the identifier, then idle bus
      bits.delete();
      bits.push_back(1'b0);
      bits.push_back(1'b1);
      repeat (6) bits.push_back(1'b0);
      repeat (16) bits.push_back(1'b1);
      send(bits.size());
      check("stuff_err_id11_held", bit_id_11, last_exp.id11);
      check("stuff_err_size_held", data_size, last_exp.size);
      check("stuff_err_rtr_held",  rtr_ext,   last_exp.rtr_ext);

      // recovery frame: all-ones identifier and zero data stress both stuff polarities
      build(1'b0, 11'h7FF, 18'h0, 1'b0, 4'd1, 64'h00, 15'h0000, e);
      sb.push_back(e); send(bits.size());

      // reset in the middle of the data field
      build(1'b0, 11'h0AB, 18'h0, 1'b0, 4'd8, 64'hDEADBEEFCAFEF00D, 15'h3333, e);
      send(30);
      @(negedge sample);
      rst_n = 1'b0;
      #1;
      check("midrst_getframe",   getframe,   1'b0);
      check("midrst_bit_id_11",  bit_id_11,  11'd0);
      check("midrst_data_field", data_field, 65'd0);
      check("midrst_ext_frame",  ext_frame,  1'b0);
      check("midrst_crc",        crc_field,  15'd0);
      repeat (2) @(negedge sample);
      can_data = 1'b1;
      rst_n    = 1'b1;
      repeat (3) @(negedge sample);

      // DLC above eight still carries eight bytes
      build(1'b1, 11'h3C5, 18'h2AAAA, 1'b0, 4'd9, 64'hFFFF0000FFFF0000, 15'h5A5A, e);
      sb.push_back(e); send(bits.size());

      repeat (4) @(negedge sample);
      check("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
